// File: rtl/dfii_init_pkg.sv
// rtl/dfii_init_pkg.sv - shared types, CSR offsets and step helpers for the DFII init sequencer
// Purpose: CSR word offsets relative to DFII_CONTROL, DFII control/command bit values,
//          the step opcode and FSM state enums, the step record and its builders.
// Ports:   none (package).
package dfii_init_pkg;

   localparam int NUM_STEPS = 30;
   localparam int IDX_W     = $clog2(NUM_STEPS + 1);

   // CSR word offsets from DFII_CONTROL
   localparam logic [2:0] CTRL  = 3'd0;
   localparam logic [2:0] CMD   = 3'd1;
   localparam logic [2:0] ISSUE = 3'd2;
   localparam logic [2:0] ADDR  = 3'd3;
   localparam logic [2:0] BADDR = 3'd4;

   // DFII_CONTROL bits
   localparam logic [31:0] DFII_SEL     = 32'h01;
   localparam logic [31:0] DFII_CKE     = 32'h02;
   localparam logic [31:0] DFII_ODT     = 32'h04;
   localparam logic [31:0] DFII_RESET_N = 32'h08;

   // p0 command bits
   localparam logic [31:0] CMD_CS  = 32'h01;
   localparam logic [31:0] CMD_WE  = 32'h02;
   localparam logic [31:0] CMD_CAS = 32'h04;
   localparam logic [31:0] CMD_RAS = 32'h08;

   localparam logic [31:0] CMD_MRS  = CMD_RAS | CMD_CAS | CMD_WE | CMD_CS;
   localparam logic [31:0] CMD_ZQCL = CMD_WE | CMD_CS;

   typedef enum logic [1:0] {OP_WRITE, OP_WAIT, OP_END} op_e;

   // ST_STEP is the one-cycle decode gap between steps; it keeps cyc low between writes.
   typedef enum logic [2:0] {
      ST_IDLE, ST_STEP, ST_WRITE, ST_WAIT, ST_DONE, ST_ERROR
   } state_e;

   typedef struct packed {
      op_e         op;
      logic [2:0]  offset;
      logic [31:0] data;
   } step_t;

   function automatic step_t step_wr(input logic [2:0] off, input logic [31:0] data);
      step_t s;
      s.op     = OP_WRITE;
      s.offset = off;
      s.data   = data;
      return s;
   endfunction

   function automatic step_t step_wait(input logic [31:0] cycles);
      step_t s;
      s.op     = OP_WAIT;
      s.offset = CTRL;
      s.data   = cycles;
      return s;
   endfunction

   function automatic step_t step_end();
      step_t s;
      s.op     = OP_END;
      s.offset = CTRL;
      s.data   = 32'd0;
      return s;
   endfunction

   // One of the four writes of a DFII command: address, bank address, command, issue.
   function automatic step_t step_cmd(input logic [1:0] sub, input logic [31:0] addr,
                                      input logic [31:0] ba, input logic [31:0] cmd);
      case (sub)
         2'd0:    return step_wr(ADDR, addr);
         2'd1:    return step_wr(BADDR, ba);
         2'd2:    return step_wr(CMD, cmd);
         default: return step_wr(ISSUE, 32'd1);
      endcase
   endfunction

   function automatic state_e op_to_state(input op_e op);
      case (op)
         OP_WRITE: return ST_WRITE;
         OP_WAIT:  return ST_WAIT;
         default:  return ST_DONE;
      endcase
   endfunction

endpackage

// File: rtl/dfii_init_rom.sv
// rtl/dfii_init_rom.sv - combinational step table of the DDR3 DFII init sequence
// Purpose: maps a step index to {op, CSR offset, data}; for OP_WAIT data is the cycle count.
// Ports:   i_index  step index
//          o_op     step opcode (write / wait / end)
//          o_offset CSR word offset from DFII_CONTROL
//          o_data   write data or wait cycle count
module dfii_init_rom
   import dfii_init_pkg::*;
#(
   parameter int unsigned T_RESET_CYC = 50000,
   parameter int unsigned T_CKE_CYC   = 50000,
   parameter int unsigned T_MRD_CYC   = 200,
   parameter int unsigned T_ZQ_CYC    = 200,
   parameter logic [31:0] MR0         = 32'h320,
   parameter logic [31:0] MR1         = 32'h6,
   parameter logic [31:0] MR2         = 32'h200,
   parameter logic [31:0] MR3         = 32'h0
) (
   input  logic [IDX_W-1:0] i_index,
   output op_e              o_op,
   output logic [2:0]       o_offset,
   output logic [31:0]      o_data
);

   step_t      w_step;
   logic [1:0] w_mrs_sub;

   // MRS groups start at step 7, so the sub-step is (index - 7) mod 4 == (index + 1) mod 4.
   assign w_mrs_sub = i_index[1:0] + 2'd1;

   always_comb begin
      w_step = step_end();
      case (i_index)
         5'd0:                      w_step = step_wr(CTRL, DFII_CKE | DFII_ODT | DFII_RESET_N);
         5'd1:                      w_step = step_wr(ADDR, 32'd0);
         5'd2:                      w_step = step_wr(BADDR, 32'd0);
         5'd3:                      w_step = step_wr(CTRL, DFII_ODT | DFII_RESET_N);
         5'd4:                      w_step = step_wait(32'(T_RESET_CYC));
         5'd5:                      w_step = step_wr(CTRL, DFII_CKE | DFII_ODT | DFII_RESET_N);
         5'd6:                      w_step = step_wait(32'(T_CKE_CYC));
         5'd7, 5'd8, 5'd9, 5'd10:   w_step = step_cmd(w_mrs_sub, MR2, 32'd2, CMD_MRS);
         5'd11, 5'd12, 5'd13, 5'd14: w_step = step_cmd(w_mrs_sub, MR3, 32'd3, CMD_MRS);
         5'd15, 5'd16, 5'd17, 5'd18: w_step = step_cmd(w_mrs_sub, MR1, 32'd1, CMD_MRS);
         5'd19, 5'd20, 5'd21, 5'd22: w_step = step_cmd(w_mrs_sub, MR0, 32'd0, CMD_MRS);
         5'd23:                     w_step = step_wait(32'(T_MRD_CYC));
         // A10 high selects ZQCL (long calibration)
         5'd24, 5'd25, 5'd26, 5'd27: w_step = step_cmd(i_index[1:0], 32'h400, 32'd0, CMD_ZQCL);
         5'd28:                     w_step = step_wait(32'(T_ZQ_CYC));
         5'd29:                     w_step = step_wr(CTRL, DFII_SEL);
         default:                   w_step = step_end();
      endcase
   end

   assign o_op     = w_step.op;
   assign o_offset = w_step.offset;
   assign o_data   = w_step.data;

endmodule

// File: rtl/dfii_init_sequencer.sv
// rtl/dfii_init_sequencer.sv - DDR3 power-up sequencer, Wishbone master on the DFII CSR bus
// Purpose: replays reset/CKE, MR2/MR3/MR1/MR0, ZQCL and hands control to hardware.
// Build option: DFII_INIT_TIMEOUT_EN - abandon a write after ACK_TIMEOUT cycles without ack
//               and enter ERROR; without it WRITE waits forever and o_error is 0.
// Ports:   i_clk, i_rst (async, active high), i_start (pulse)
//          o_busy, o_done, o_error status
//          o_wb_adr/o_wb_dat_w/o_wb_sel/o_wb_cyc/o_wb_stb/o_wb_we, i_wb_ack Wishbone master
module dfii_init_sequencer
   import dfii_init_pkg::*;
#(
   parameter logic [29:0] CSR_BASE    = 30'h2400,
   parameter int unsigned T_RESET_CYC = 50000,
   parameter int unsigned T_CKE_CYC   = 50000,
   parameter int unsigned T_MRD_CYC   = 200,
   parameter int unsigned T_ZQ_CYC    = 200,
   parameter logic [31:0] MR0         = 32'h320,
   parameter logic [31:0] MR1         = 32'h6,
   parameter logic [31:0] MR2         = 32'h200,
   parameter logic [31:0] MR3         = 32'h0,
   parameter int unsigned ACK_TIMEOUT = 1024
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_start,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_error,
   output logic [29:0] o_wb_adr,
   output logic [31:0] o_wb_dat_w,
   output logic [3:0]  o_wb_sel,
   output logic        o_wb_cyc,
   output logic        o_wb_stb,
   output logic        o_wb_we,
   input  logic        i_wb_ack
);

   state_e           r_state, w_next;
   logic [IDX_W-1:0] r_index, w_rom_idx;
   logic [31:0]      r_wait;
   op_e              w_op;
   logic [2:0]       w_offset;
   logic [31:0]      w_data;
   logic             w_accept, w_wr_done, w_wait_done, w_tmo_hit, w_cyc;

   assign w_accept    = i_start &&
                        (r_state == ST_IDLE || r_state == ST_DONE || r_state == ST_ERROR);
   // On acceptance the table is read at step 0 so the first step starts immediately.
   assign w_rom_idx   = w_accept ? '0 : r_index;
   assign w_wr_done   = (r_state == ST_WRITE) && i_wb_ack;
   assign w_wait_done = (r_state == ST_WAIT) && (r_wait == 32'd0);

   dfii_init_rom #(
      .T_RESET_CYC (T_RESET_CYC),
      .T_CKE_CYC   (T_CKE_CYC),
      .T_MRD_CYC   (T_MRD_CYC),
      .T_ZQ_CYC    (T_ZQ_CYC),
      .MR0         (MR0),
      .MR1         (MR1),
      .MR2         (MR2),
      .MR3         (MR3)
   ) u_rom (
      .i_index  (w_rom_idx),
      .o_op     (w_op),
      .o_offset (w_offset),
      .o_data   (w_data)
   );

`ifdef DFII_INIT_TIMEOUT_EN
   logic [31:0] r_tmo;

   assign w_tmo_hit = (r_tmo == 32'(ACK_TIMEOUT - 1));

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         r_tmo <= '0;
      else if (r_state == ST_WRITE && !i_wb_ack)
         r_tmo <= r_tmo + 32'd1;
      else
         r_tmo <= '0;
   end
`else
   logic w_unused_ack_timeout;

   assign w_tmo_hit            = 1'b0;
   assign w_unused_ack_timeout = (ACK_TIMEOUT == 0);
`endif

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         r_state <= ST_IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE, ST_DONE, ST_ERROR: if (i_start) w_next = op_to_state(w_op);
         ST_STEP:  w_next = op_to_state(w_op);
         ST_WRITE: begin
            if (i_wb_ack)
               w_next = ST_STEP;
            else if (w_tmo_hit)
               w_next = ST_ERROR;
         end
         ST_WAIT:  if (w_wait_done) w_next = ST_STEP;
         default:  w_next = ST_IDLE;
      endcase
   end

   // Step index and wait counter
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_index <= '0;
         r_wait  <= '0;
      end else begin
         if (w_accept)
            r_index <= '0;
         else if (w_wr_done || w_wait_done)
            r_index <= r_index + IDX_W'(1);

         // Load N-1 on entry so WAIT lasts exactly N cycles; N = 0 behaves as 1.
         if (w_next == ST_WAIT && r_state != ST_WAIT)
            r_wait <= (w_data == 32'd0) ? 32'd0 : w_data - 32'd1;
         else if (r_state == ST_WAIT && r_wait != 32'd0)
            r_wait <= r_wait - 32'd1;
      end
   end

   // Bus outputs follow the state register directly, so an async reset drops cyc at once.
   assign w_cyc = (r_state == ST_WRITE);

   always_comb begin
      o_busy     = (r_state == ST_STEP) || (r_state == ST_WRITE) || (r_state == ST_WAIT);
      o_done     = (r_state == ST_DONE);
`ifdef DFII_INIT_TIMEOUT_EN
      o_error    = (r_state == ST_ERROR);
`else
      o_error    = 1'b0;
`endif
      o_wb_cyc   = w_cyc;
      o_wb_stb   = w_cyc;
      o_wb_we    = w_cyc;
      o_wb_sel   = w_cyc ? 4'hF : 4'h0;
      o_wb_adr   = w_cyc ? CSR_BASE + 30'(w_offset) : 30'd0;
      o_wb_dat_w = w_cyc ? w_data : 32'd0;
   end

endmodule

// File: tb/tb_dfii_init_sequencer.sv
// tb/tb_dfii_init_sequencer.sv - directed self-checking bench for dfii_init_sequencer
module tb_dfii_init_sequencer;

   localparam int DLY_RESET = 5;
   localparam int DLY_CKE   = 3;
   localparam int DLY_MRD   = 2;
   localparam int NWR       = 26;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        wb_ack = 1'b0;
   logic        busy, done, error, wb_cyc, wb_stb, wb_we;
   logic [29:0] wb_adr;
   logic [31:0] wb_dat_w;
   logic [3:0]  wb_sel;

   dfii_init_sequencer #(
      .CSR_BASE    (30'h2400),
      .T_RESET_CYC (DLY_RESET),
      .T_CKE_CYC   (DLY_CKE),
      .T_MRD_CYC   (DLY_MRD),
      .T_ZQ_CYC    (0),
      .ACK_TIMEOUT (16)
   ) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_start    (start),
      .o_busy     (busy),
      .o_done     (done),
      .o_error    (error),
      .o_wb_adr   (wb_adr),
      .o_wb_dat_w (wb_dat_w),
      .o_wb_sel   (wb_sel),
      .o_wb_cyc   (wb_cyc),
      .o_wb_stb   (wb_stb),
      .o_wb_we    (wb_we),
      .i_wb_ack   (wb_ack)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   int exp_off[NWR] = '{0, 3, 4, 0, 0,
                        3, 4, 1, 2,  3, 4, 1, 2,  3, 4, 1, 2,  3, 4, 1, 2,
                        3, 4, 1, 2,  0};
   int exp_dat[NWR] = '{'h0E, 0, 0, 'h0C, 'h0E,
                        'h200, 2, 'h0F, 1,  'h0, 3, 'h0F, 1,  'h6, 1, 'h0F, 1,
                        'h320, 0, 'h0F, 1,  'h400, 0, 'h03, 1,  'h01};

   // Slave model and write monitor, evaluated on the falling edge.
   int          slave_delay = 1;
   bit          slave_rand  = 1'b0;
   int          stall_write = -1;
   int          k = 0;
   int          d = 0;
   int          cyc_n = 0;
   int          n_writes = 0;
   int          proto_err = 0;
   logic [29:0] cur_adr;
   logic [31:0] cur_dat;
   int          cur_rise;
   logic [29:0] mon_adr [64];
   logic [31:0] mon_dat [64];
   int          mon_rise[64];
   int          mon_ack [64];
   bit          timed_out;

   always @(negedge clk) begin
      cyc_n++;
      if (wb_cyc) begin
         if (k == 0) begin
            d        = slave_rand ? int'($urandom_range(0, 7)) : slave_delay;
            cur_adr  = wb_adr;
            cur_dat  = wb_dat_w;
            cur_rise = cyc_n;
         end else if (wb_adr !== cur_adr || wb_dat_w !== cur_dat) begin
            proto_err++;
         end
         if (wb_sel !== 4'hF || wb_we !== 1'b1 || wb_stb !== 1'b1)
            proto_err++;
         wb_ack = (k >= d) && (n_writes != stall_write);
         if (wb_ack && n_writes < 64) begin
            mon_adr[n_writes]  = wb_adr;
            mon_dat[n_writes]  = wb_dat_w;
            mon_rise[n_writes] = cur_rise;
            mon_ack[n_writes]  = cyc_n;
            n_writes++;
         end
         k++;
      end else begin
         wb_ack = 1'b0;
         k      = 0;
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic clear_mon();
      n_writes  = 0;
      proto_err = 0;
      for (int i = 0; i < 64; i++) begin
         mon_adr[i] = 'x;
         mon_dat[i] = 'x;
      end
   endtask

   task automatic run_to_end(input int budget);
      timed_out = 1'b1;
      for (int i = 0; i < budget; i++) begin
         if (done || error) begin
            timed_out = 1'b0;
            break;
         end
         tick();
      end
   endtask

   task automatic wait_write(input int idx, input int budget);
      timed_out = 1'b1;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (n_writes == idx && wb_cyc) begin
            timed_out = 1'b0;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      checks++;
      if ({busy, done, error, wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_w} !== '0) begin
         errors++;
         $display("FAIL reset_in: busy=%b done=%b error=%b cyc=%b adr=%h dat=%h sel=%h expected all 0",
                  busy, done, error, wb_cyc, wb_adr, wb_dat_w, wb_sel);
      end
      rst = 1'b0;
      tick();
      checks++;
      if ({busy, done, error, wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_w} !== '0) begin
         errors++;
         $display("FAIL reset_after: busy=%b done=%b error=%b cyc=%b expected all 0",
                  busy, done, error, wb_cyc);
      end
   endtask

   task automatic test_full_sequence();
      slave_rand  = 1'b0;
      slave_delay = 1;
      clear_mon();
      pulse_start();
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("FAIL full_busy: busy=%b done=%b expected 1 0", busy, done);
      end
      run_to_end(3000);
      checks++;
      if (timed_out) begin
         errors++;
         $display("FAIL full_timeout: done never rose (got 0 expected 1)");
      end
      checks++;
      if (n_writes != NWR) begin
         errors++;
         $display("FAIL full_count: got %0d expected %0d", n_writes, NWR);
      end
      for (int i = 0; i < NWR; i++) begin
         checks++;
         if (mon_adr[i] !== 30'h2400 + 30'(exp_off[i]) || mon_dat[i] !== 32'(exp_dat[i])) begin
            errors++;
            $display("FAIL full_write%0d: adr=%h dat=%h expected adr=%h dat=%h", i, mon_adr[i],
                     mon_dat[i], 30'h2400 + 30'(exp_off[i]), 32'(exp_dat[i]));
         end
      end
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || error !== 1'b0) begin
         errors++;
         $display("FAIL full_status: done=%b busy=%b error=%b expected 1 0 0", done, busy, error);
      end
      checks++;
      if (proto_err != 0) begin
         errors++;
         $display("FAIL full_protocol: got %0d violations expected 0", proto_err);
      end
      // ack -> STEP -> next cyc is 2 cycles; a WAIT of N adds N plus one more STEP.
      checks++;
      if (mon_rise[1] - mon_ack[0] != 2) begin
         errors++;
         $display("FAIL gap_write: got %0d expected 2", mon_rise[1] - mon_ack[0]);
      end
      checks++;
      if (mon_rise[4] - mon_ack[3] != DLY_RESET + 3) begin
         errors++;
         $display("FAIL gap_t_reset: got %0d expected %0d", mon_rise[4] - mon_ack[3], DLY_RESET + 3);
      end
      checks++;
      if (mon_rise[5] - mon_ack[4] != DLY_CKE + 3) begin
         errors++;
         $display("FAIL gap_t_cke: got %0d expected %0d", mon_rise[5] - mon_ack[4], DLY_CKE + 3);
      end
      checks++;
      if (mon_rise[21] - mon_ack[20] != DLY_MRD + 3) begin
         errors++;
         $display("FAIL gap_t_mrd: got %0d expected %0d", mon_rise[21] - mon_ack[20], DLY_MRD + 3);
      end
      checks++;
      if (mon_rise[25] - mon_ack[24] != 1 + 3) begin
         errors++;
         $display("FAIL gap_t_zq0: got %0d expected 4", mon_rise[25] - mon_ack[24]);
      end
   endtask

   task automatic test_zero_delay_ack();
      slave_rand  = 1'b0;
      slave_delay = 0;
      clear_mon();
      pulse_start();
      run_to_end(3000);
      checks++;
      if (timed_out || n_writes != NWR || done !== 1'b1) begin
         errors++;
         $display("FAIL zero_ack_run: writes=%0d done=%b expected %0d 1", n_writes, done, NWR);
      end
      for (int i = 0; i < NWR; i++) begin
         checks++;
         if (mon_adr[i] !== 30'h2400 + 30'(exp_off[i]) || mon_dat[i] !== 32'(exp_dat[i])) begin
            errors++;
            $display("FAIL zero_ack_write%0d: adr=%h dat=%h expected adr=%h dat=%h", i, mon_adr[i],
                     mon_dat[i], 30'h2400 + 30'(exp_off[i]), 32'(exp_dat[i]));
         end
      end
      checks++;
      if (mon_rise[1] - mon_ack[0] != 2 || mon_ack[0] != mon_rise[0]) begin
         errors++;
         $display("FAIL zero_ack_gap: got %0d expected 2", mon_rise[1] - mon_ack[0]);
      end
      checks++;
      if (proto_err != 0) begin
         errors++;
         $display("FAIL zero_ack_protocol: got %0d expected 0", proto_err);
      end
   endtask

   task automatic test_random_delay_ack();
      slave_rand = 1'b1;
      clear_mon();
      pulse_start();
      run_to_end(5000);
      slave_rand = 1'b0;
      checks++;
      if (timed_out || n_writes != NWR || done !== 1'b1) begin
         errors++;
         $display("FAIL rand_ack_run: writes=%0d done=%b expected %0d 1", n_writes, done, NWR);
      end
      for (int i = 0; i < NWR; i++) begin
         checks++;
         if (mon_adr[i] !== 30'h2400 + 30'(exp_off[i]) || mon_dat[i] !== 32'(exp_dat[i])) begin
            errors++;
            $display("FAIL rand_ack_write%0d: adr=%h dat=%h expected adr=%h dat=%h", i, mon_adr[i],
                     mon_dat[i], 30'h2400 + 30'(exp_off[i]), 32'(exp_dat[i]));
         end
      end
      checks++;
      if (proto_err != 0) begin
         errors++;
         $display("FAIL rand_ack_protocol: got %0d expected 0", proto_err);
      end
   endtask

   task automatic test_start_ignored();
      slave_delay = 1;
      clear_mon();
      pulse_start();
      wait_write(8, 500);   // write 8 is step 10
      checks++;
      if (timed_out) begin
         errors++;
         $display("FAIL ignore_reach: step 10 not reached (got 0 expected 1)");
      end
      pulse_start();
      run_to_end(3000);
      checks++;
      if (timed_out || n_writes != NWR || done !== 1'b1) begin
         errors++;
         $display("FAIL ignore_run: writes=%0d done=%b expected %0d 1", n_writes, done, NWR);
      end
      for (int i = 0; i < NWR; i++) begin
         checks++;
         if (mon_adr[i] !== 30'h2400 + 30'(exp_off[i]) || mon_dat[i] !== 32'(exp_dat[i])) begin
            errors++;
            $display("FAIL ignore_write%0d: adr=%h dat=%h expected adr=%h dat=%h", i, mon_adr[i],
                     mon_dat[i], 30'h2400 + 30'(exp_off[i]), 32'(exp_dat[i]));
         end
      end
   endtask

   task automatic test_restart_after_done();
      slave_delay = 1;
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL restart_pre: done=%b expected 1", done);
      end
      clear_mon();
      pulse_start();
      checks++;
      if (done !== 1'b0 || wb_cyc !== 1'b1 || wb_adr !== 30'h2400 || wb_dat_w !== 32'h0E) begin
         errors++;
         $display("FAIL restart_first: done=%b cyc=%b adr=%h dat=%h expected 0 1 2400 0000000e",
                  done, wb_cyc, wb_adr, wb_dat_w);
      end
      run_to_end(3000);
      checks++;
      if (timed_out || n_writes != NWR || done !== 1'b1) begin
         errors++;
         $display("FAIL restart_run: writes=%0d done=%b expected %0d 1", n_writes, done, NWR);
      end
   endtask

   task automatic test_reset_mid_write();
      slave_delay = 1;
      clear_mon();
      pulse_start();
      wait_write(10, 500);  // write 10 is step 12
      checks++;
      if (timed_out) begin
         errors++;
         $display("FAIL midrst_reach: step 12 not reached (got 0 expected 1)");
      end
      rst = 1'b1;
      #1;
      checks++;
      if (wb_cyc !== 1'b0 || wb_stb !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL midrst_drop: cyc=%b stb=%b busy=%b done=%b expected 0 0 0 0",
                  wb_cyc, wb_stb, busy, done);
      end
      tick();
      tick();
      rst = 1'b0;
      tick();
      clear_mon();
      pulse_start();
      checks++;
      if (wb_cyc !== 1'b1 || wb_adr !== 30'h2400 || wb_dat_w !== 32'h0E) begin
         errors++;
         $display("FAIL midrst_first: cyc=%b adr=%h dat=%h expected 1 2400 0000000e",
                  wb_cyc, wb_adr, wb_dat_w);
      end
      run_to_end(3000);
      checks++;
      if (timed_out || n_writes != NWR || done !== 1'b1) begin
         errors++;
         $display("FAIL midrst_run: writes=%0d done=%b expected %0d 1", n_writes, done, NWR);
      end
      for (int i = 0; i < NWR; i++) begin
         checks++;
         if (mon_adr[i] !== 30'h2400 + 30'(exp_off[i]) || mon_dat[i] !== 32'(exp_dat[i])) begin
            errors++;
            $display("FAIL midrst_write%0d: adr=%h dat=%h expected adr=%h dat=%h", i, mon_adr[i],
                     mon_dat[i], 30'h2400 + 30'(exp_off[i]), 32'(exp_dat[i]));
         end
      end
   endtask

`ifdef DFII_INIT_TIMEOUT_EN
   task automatic test_ack_timeout();
      int cnt;
      slave_delay = 1;
      clear_mon();
      stall_write = 5;      // write 5 is step 7
      pulse_start();
      wait_write(5, 500);
      cnt = 0;
      while (wb_cyc && cnt < 100) begin
         cnt++;
         tick();
      end
      checks++;
      if (cnt != 16) begin
         errors++;
         $display("FAIL tmo_cycles: got %0d expected 16", cnt);
      end
      checks++;
      if (error !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || wb_cyc !== 1'b0) begin
         errors++;
         $display("FAIL tmo_status: error=%b busy=%b done=%b cyc=%b expected 1 0 0 0",
                  error, busy, done, wb_cyc);
      end
      stall_write = -1;
      clear_mon();
      pulse_start();
      checks++;
      if (error !== 1'b0) begin
         errors++;
         $display("FAIL tmo_clear: error=%b expected 0", error);
      end
      run_to_end(3000);
      checks++;
      if (timed_out || n_writes != NWR || done !== 1'b1 || error !== 1'b0) begin
         errors++;
         $display("FAIL tmo_recover: writes=%0d done=%b error=%b expected %0d 1 0",
                  n_writes, done, error, NWR);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_full_sequence();
      test_zero_delay_ack();
      test_random_delay_ack();
      test_start_ignored();
      test_restart_after_done();
      test_reset_mid_write();
`ifdef DFII_INIT_TIMEOUT_EN
      test_ack_timeout();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
